// File: rtl/spi_xfer_ctrl_if.sv
// Upstream command/data handshake between the command logic and the SPI
// transfer controller.
//   master : command logic (drives start/xfer_len/tx_data)
//   slave  : spi_xfer_ctrl (returns tx_ack/rx_data/rx_valid/busy/done)
interface spi_xfer_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) ();
  logic              start;
  logic [LEN_W-1:0]  xfer_len;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ack;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              done;

  modport master (output start, xfer_len, tx_data,
                  input  tx_ack, rx_data, rx_valid, busy, done);
  modport slave  (input  start, xfer_len, tx_data,
                  output tx_ack, rx_data, rx_valid, busy, done);
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 (CPOL=0, CPHA=0) multi-word master transfer sequencer, MSB first.
// SCK timing comes from external single-cycle lead (rise) / trail (fall)
// strobes; this block owns chip-select setup/hold and per-word handshakes.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   edge_lead, edge_trail SCK rise / fall strobes from the divider
//   cmd (slave)           start/xfer_len/tx_data in; tx_ack/rx_data/
//                         rx_valid/busy/done out
//   spi_cs_n/sck/mosi     SPI pins out (all registered)
//   spi_miso              SPI data in
module spi_xfer_ctrl #(
  parameter int DATA_W   = 8,
  parameter int LEN_W    = 8,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             edge_lead,
  input  logic             edge_trail,
  spi_xfer_ctrl_if.slave   cmd,
  output logic             spi_cs_n,
  output logic             spi_sck,
  output logic             spi_mosi,
  input  logic             spi_miso
);
  localparam int BC_W    = $clog2(DATA_W) + 1;
  localparam int GAP_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);
  localparam logic [BC_W-1:0]  BIT_LAST   = BC_W'(DATA_W);
  localparam logic [GAP_W-1:0] SETUP_LAST = GAP_W'(CS_SETUP - 1);
  localparam logic [GAP_W-1:0] HOLD_LAST  = GAP_W'(CS_HOLD - 1);
  localparam logic [LEN_W-1:0] ONE_WORD   = LEN_W'(1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t            state_q, state_d;
  // one counter serves both the CS setup and CS hold gaps (never overlap)
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [BC_W-1:0]   bit_q, bit_d;
  logic [LEN_W-1:0]  words_q, words_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic              cs_n_q, cs_n_d, sck_q, sck_d, mosi_q, mosi_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              tx_ack_q, tx_ack_d, rx_valid_q, rx_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      bit_q      <= '0;
      words_q    <= '0;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      cs_n_q     <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_ack_q   <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      bit_q      <= bit_d;
      words_q    <= words_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      cs_n_q     <= cs_n_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_ack_q   <= tx_ack_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    bit_d      = bit_q;
    words_d    = words_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    cs_n_d     = cs_n_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_ack_d   = 1'b0;
    rx_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd.start && cmd.xfer_len != '0) begin
          words_d  = cmd.xfer_len;
          tx_d     = cmd.tx_data;
          mosi_d   = cmd.tx_data[DATA_W-1];
          cs_n_d   = 1'b0;
          busy_d   = 1'b1;
          tx_ack_d = 1'b1;
          gap_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (edge_trail) begin
          if (gap_q == SETUP_LAST) begin
            bit_d   = '0;
            state_d = SHIFT;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      SHIFT: begin
        // trail wins over a coincident lead; a trail before the word's
        // first lead (bit_q == 0) is not an SCK fall and is ignored
        if (edge_trail) begin
          if (bit_q == BIT_LAST) begin
            sck_d      = 1'b0;
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            words_d    = words_q - 1'b1;
            if (words_q > ONE_WORD) begin
              tx_d     = cmd.tx_data;
              mosi_d   = cmd.tx_data[DATA_W-1];
              tx_ack_d = 1'b1;
              bit_d    = '0;
            end else begin
              gap_d   = '0;
              state_d = HOLD;
            end
          end else if (bit_q != '0) begin
            sck_d  = 1'b0;
            mosi_d = tx_q[DATA_W-2];
            tx_d   = tx_q << 1;
          end
        end else if (edge_lead && bit_q != BIT_LAST) begin
          sck_d   = 1'b1;
          rx_sh_d = {rx_sh_q[DATA_W-2:0], spi_miso};
          bit_d   = bit_q + 1'b1;
        end
      end
      HOLD: begin
        if (edge_trail) begin
          if (gap_q == HOLD_LAST) begin
            cs_n_d  = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd.tx_ack   = tx_ack_q;
  assign cmd.rx_data  = rx_data_q;
  assign cmd.rx_valid = rx_valid_q;
  assign cmd.busy     = busy_q;
  assign cmd.done     = done_q;
  assign spi_cs_n     = cs_n_q;
  assign spi_sck      = sck_q;
  assign spi_mosi     = mosi_q;
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Randomized + directed bench for spi_xfer_ctrl with a queue scoreboard.
// MISO is looped to MOSI, so each received word must equal the word sent.
module tb_spi_xfer_ctrl;
  localparam int CS_HOLD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic edge_lead = 1'b0, edge_trail = 1'b0;
  logic spi_cs_n, spi_sck, spi_mosi;

  spi_xfer_ctrl_if bus ();

  spi_xfer_ctrl #(.DATA_W(8), .LEN_W(8), .CS_SETUP(2), .CS_HOLD(CS_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .edge_lead(edge_lead), .edge_trail(edge_trail),
    .cmd(bus), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_mosi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_rx[$];   // expected words, in order
  int         exp_len[$];  // expected transfer lengths, one per done
  logic [7:0] tx_pend[$];  // words upstream still has to present
  int         inject_req = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // SCK strobe source: every 25 clk, alternating lead/trail. A pending
  // inject request turns the next trail slot into a coincident lead+trail.
  initial begin
    int cnt = 0;
    bit lead_next = 1'b1;
    int inject_used = 0;
    forever begin
      @(posedge clk); #1;
      edge_lead = 1'b0; edge_trail = 1'b0;
      cnt++;
      if (cnt == 25) begin
        cnt = 0;
        if (lead_next) edge_lead = 1'b1;
        else begin
          edge_trail = 1'b1;
          if (inject_req != inject_used) begin
            edge_lead = 1'b1;
            inject_used++;
          end
        end
        lead_next = ~lead_next;
      end
    end
  end

  // Upstream data source: presents the head of tx_pend, advances on tx_ack.
  initial begin
    bus.tx_data = '0;
    forever begin
      @(negedge clk);
      if (bus.tx_ack && tx_pend.size() > 0) void'(tx_pend.pop_front());
      if (tx_pend.size() > 0) bus.tx_data = tx_pend[0];
    end
  end

  // Monitor / scoreboard
  initial begin
    int rises = 0, acks = 0, trails = 0, len;
    logic sck_prev = 1'b0;
    logic [7:0] mosi_word = '0, e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rises = 0; acks = 0; trails = 0; sck_prev = 1'b0;
      end else begin
        if (spi_sck && !sck_prev) begin
          rises++;
          mosi_word = {mosi_word[6:0], spi_mosi};
        end
        sck_prev = spi_sck;
        if (bus.tx_ack) acks++;
        if (edge_trail) trails++;
        if (bus.rx_valid) begin
          if (exp_rx.size() == 0) chk("unexpected_rx_valid", 1, 0);
          else begin
            e = exp_rx.pop_front();
            chk("rx_data", {24'd0, bus.rx_data}, {24'd0, e});
            chk("mosi_word", {24'd0, mosi_word}, {24'd0, e});
          end
          trails = 0;
        end
        if (bus.done) begin
          if (exp_len.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            len = exp_len.pop_front();
            chk("sck_rises", rises, 8 * len);
            chk("tx_ack_count", acks, len);
            chk("hold_trails", trails, CS_HOLD);
            chk("cs_n_at_done", {31'd0, spi_cs_n}, 1);
            chk("busy_at_done", {31'd0, bus.busy}, 0);
          end
          rises = 0; acks = 0;
        end
      end
    end
  end

  task automatic begin_xfer(input int len, input logic [7:0] w[$]);
    foreach (w[i]) begin
      tx_pend.push_back(w[i]);
      exp_rx.push_back(w[i]);
    end
    exp_len.push_back(len);
    @(negedge clk);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.xfer_len = 8'(len);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("cs_n_low_1clk", {31'd0, spi_cs_n}, 0);
    chk("busy_after_start", {31'd0, bus.busy}, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  initial begin
    logic [7:0] w[$];
    int bad, len;
    bus.start = 1'b0; bus.xfer_len = '0;
    #23;
    chk("rst_cs_n", {31'd0, spi_cs_n}, 1);
    chk("rst_outs", {26'd0, spi_sck, spi_mosi, bus.busy, bus.done, bus.tx_ack, bus.rx_valid}, 0);
    chk("rst_rx_data", {24'd0, bus.rx_data}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // T1
    w = '{8'hA5}; begin_xfer(1, w); wait_done();
    // T2
    w = '{8'h01, 8'h80, 8'hFF}; begin_xfer(3, w); wait_done();

    // T3: zero length is ignored
    @(posedge clk); #1 bus.start = 1'b1; bus.xfer_len = '0;
    @(posedge clk); #1 bus.start = 1'b0;
    bad = 0;
    repeat (120) begin
      @(negedge clk);
      if (!spi_cs_n || bus.busy || bus.done || bus.tx_ack) bad++;
    end
    chk("len0_ignored", bad, 0);

    // T4: start while busy is ignored
    w = '{8'h5A, 8'hC3, 8'h96}; begin_xfer(3, w);
    begin
      int k = 0;
      while (!bus.rx_valid && k < 5000) begin @(negedge clk); k++; end
      if (k >= 5000) chk("t4_first_word_timeout", 0, 1);
    end
    @(posedge clk); #1 bus.start = 1'b1; bus.xfer_len = 8'd2;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done();
    repeat (400) @(negedge clk);
    chk("t4_no_extra_words", exp_rx.size(), 0);

    // T5: async reset after SCK rise 4 of word 1
    w = '{8'hE7}; begin_xfer(1, w);
    begin
      int r = 0, k = 0;
      logic p = 1'b0;
      while (r < 4 && k < 5000) begin
        @(negedge clk); k++;
        if (spi_sck && !p) r++;
        p = spi_sck;
      end
      if (k >= 5000) chk("t5_rise_timeout", 0, 1);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    exp_rx.delete(); exp_len.delete(); tx_pend.delete();
    #1;
    chk("t5_cs_n", {31'd0, spi_cs_n}, 1);
    chk("t5_sck", {31'd0, spi_sck}, 0);
    chk("t5_busy", {31'd0, bus.busy}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    w = '{8'h3C}; begin_xfer(1, w); wait_done();

    // T6: coincident lead+trail mid-word
    w = '{8'h69, 8'hB2}; begin_xfer(2, w);
    begin
      int r = 0, k = 0;
      logic p = 1'b0;
      while (r < 3 && k < 5000) begin
        @(negedge clk); k++;
        if (spi_sck && !p) r++;
        p = spi_sck;
      end
    end
    inject_req++;
    wait_done();

    // Randomized transfers
    repeat (6) begin
      len = $urandom_range(1, 4);
      w.delete();
      repeat (len) w.push_back(8'($urandom));
      begin_xfer(len, w);
      wait_done();
    end

    repeat (100) @(negedge clk);
    chk("rx_queue_empty", exp_rx.size(), 0);
    chk("done_queue_empty", exp_len.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
